// File: rtl/rej_parse_stream.sv
// rej_parse_stream: Kyber rejection-sampling parser, XOF bytes to coefficients.
// Optional rejected-candidate counter enabled by PARSE_REJECT_CNT_EN.
module rej_parse_stream #(
   parameter int Q       = 3329,
   parameter int N       = 256,
   parameter int TRIPLES = 1,
   parameter int OUT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [24*TRIPLES-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_W-1:0]      out_data,
   output logic [$clog2(N)-1:0]  out_idx,
   output logic                  out_last,
   output logic                  done
`ifdef PARSE_REJECT_CNT_EN
   ,
   output logic [15:0]           rej_cnt
`endif
);

   localparam int C  = 2 * TRIPLES;
   localparam int IW = $clog2(N);
   localparam int SW = $clog2(C);
   localparam logic [IW-1:0] LAST = IW'(N - 1);
   localparam logic [12:0]   QV   = 13'(Q);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [11:0]   cand [C];
   logic [11:0]   pc [C];
   logic [C-1:0]  pacc;
   logic [C-1:0]  mask;
   logic [C-1:0]  mask_nx;
   logic [C-1:0]  mask_low;
   logic [IW-1:0] count;
   logic [IW-1:0] count_nx;
   logic          done_nx;
   logic [SW-1:0] sel;
   logic          run;
   logic          any;
   logic          onehot;
   logic          in_fire;
   logic          out_fire;
   logic          clr;

   // Split each 3-byte group into its two 12-bit candidates.
   always_comb begin
      pc   = '{default: '0};
      pacc = '0;
      for (int t = 0; t < TRIPLES; t++) begin
         pc[2*t]   = {in_data[24*t+8 +: 4], in_data[24*t +: 8]};
         pc[2*t+1] = {in_data[24*t+16 +: 8], in_data[24*t+12 +: 4]};
      end
      for (int i = 0; i < C; i++) begin
         pacc[i] = ({1'b0, pc[i]} < QV);
      end
   end

   always_comb begin
      sel = '0;
      for (int i = C - 1; i >= 0; i--) begin
         if (mask[i]) sel = SW'(i);
      end
   end

   assign mask_low = mask & (mask - C'(1));
   assign any      = |mask;
   assign onehot   = any && (mask_low == '0);
   assign run      = (state == RUN);

   assign out_valid = run && any;
   assign in_ready  = run && (!any || (onehot && out_ready && count != LAST));
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   assign out_data = out_valid ? OUT_W'(cand[sel]) : '0;
   assign out_idx  = count;
   assign out_last = out_valid && (count == LAST);

   always_comb begin
      state_nx = state;
      mask_nx  = mask;
      count_nx = count;
      done_nx  = done;
      clr      = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nx = RUN;
               mask_nx  = '0;
               count_nx = '0;
               done_nx  = 1'b0;
               clr      = 1'b1;
            end
         end
         RUN: begin
            if (out_fire) begin
               mask_nx  = mask_low;
               count_nx = count + IW'(1);
               if (count == LAST) begin
                  state_nx = DONE;
                  mask_nx  = '0;
                  count_nx = count;
                  done_nx  = 1'b1;
               end
            end
            if (in_fire) mask_nx = pacc;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         mask  <= '0;
         count <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         mask  <= mask_nx;
         count <= count_nx;
         done  <= done_nx;
      end
   end

   // Candidate values need no reset; the mask qualifies them.
   always_ff @(posedge clk) begin
      if (in_fire) cand <= pc;
   end

`ifdef PARSE_REJECT_CNT_EN
   logic [4:0]  nrej;
   logic [16:0] rsum;

   always_comb begin
      nrej = '0;
      for (int i = 0; i < C; i++) begin
         nrej = nrej + 5'(!pacc[i]);
      end
      rsum = {1'b0, rej_cnt} + 17'(nrej);
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) rej_cnt <= '0;
      else if (in_fire) rej_cnt <= rsum[16] ? 16'hFFFF : rsum[15:0];
   end
`endif

endmodule

// File: tb/tb_rej_parse_stream.sv
// Bench for rej_parse_stream (TRIPLES=4) against a byte-level reference parse.
// rej_cnt checks are active when PARSE_REJECT_CNT_EN is defined.
module tb_rej_parse_stream;

   localparam int Q = 3329;
   localparam int N = 256;
   localparam int T = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic [24*T-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   out_data;
   logic [7:0]    out_idx;
   logic          out_last;
   logic          done;
`ifdef PARSE_REJECT_CNT_EN
   logic [15:0]   rej_cnt;
`endif

   int checks = 0;
   int failures = 0;
   int rej_run = 0;
   logic [95:0] beat_q[$];
   int exp_q[$];
   int last_beat;

   rej_parse_stream #(.Q(Q), .N(N), .TRIPLES(T), .OUT_W(16)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_idx(out_idx),
      .out_last(out_last),
      .done(done)
`ifdef PARSE_REJECT_CNT_EN
      ,
      .rej_cnt(rej_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int cand_of(logic [95:0] bt, int j);
      int g, b0, b1, b2;
      g  = j / 2;
      b0 = int'(bt[24*g +: 8]);
      b1 = int'(bt[24*g+8 +: 8]);
      b2 = int'(bt[24*g+16 +: 8]);
      if (j % 2 == 0) return b0 + 256 * (b1 & 15);
      return (b1 >> 4) + 16 * b2;
   endfunction

   function automatic int rej_of(logic [95:0] bt);
      int n = 0;
      for (int j = 0; j < 2*T; j++) if (cand_of(bt, j) >= Q) n++;
      return n;
   endfunction

   task automatic ref_parse();
      exp_q.delete();
      last_beat = -1;
      foreach (beat_q[b]) begin
         for (int j = 0; j < 2*T; j++) begin
            if (cand_of(beat_q[b], j) < Q && exp_q.size() < N) begin
               exp_q.push_back(cand_of(beat_q[b], j));
               if (exp_q.size() == N) last_beat = b;
            end
         end
      end
   endtask

   task automatic gen_stream();
      int acc;
      beat_q.delete();
      acc = 0;
      while (acc < N) begin
         beat_q.push_back({$urandom, $urandom, $urandom});
         acc += 2*T - rej_of(beat_q[$]);
      end
      beat_q.push_back({$urandom, $urandom, $urandom});
      beat_q.push_back({$urandom, $urandom, $urandom});
      ref_parse();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 0; in_valid = 0; out_ready = 0; in_data = '0;
      tick(); tick(); tick();
      checks++;
      if ({in_ready, out_valid, out_data, out_idx, out_last, done} !== '0) begin
         failures++;
         $display("FAIL reset_outs got=%h exp=0",
                  {in_ready, out_valid, out_data, out_idx, out_last, done});
      end
`ifdef PARSE_REJECT_CNT_EN
      checks++;
      if (rej_cnt !== 16'd0) begin
         failures++; $display("FAIL reset_rej got=%0d exp=0", rej_cnt);
      end
`endif
      rst_n = 1'b1; in_valid = 1; out_ready = 1;
      tick(); tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL idle_ready got=%b/%b exp=0/0", in_ready, out_valid);
      end
      in_valid = 0;
   endtask

   task automatic test_basic();
      logic [95:0] a;
      a = {72'hFFFFFF_FFFFFF_FFFFFF, 24'h030201};
      start = 1; tick(); start = 0;
      checks++;
      if (in_ready !== 1'b1 || done !== 1'b0) begin
         failures++;
         $display("FAIL start_ready got=%b done=%b exp=1 done=0", in_ready, done);
      end
      in_valid = 1; in_data = a; out_ready = 1;
      tick(); in_valid = 0; rej_run = rej_of(a);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'd513 || out_idx !== 8'd0) begin
         failures++;
         $display("FAIL basic_c0 got=%b/%0d/%0d exp=1/513/0", out_valid, out_data, out_idx);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'd48 || out_idx !== 8'd1 || out_last !== 1'b0) begin
         failures++;
         $display("FAIL basic_c1 got=%b/%0d/%0d exp=1/48/1", out_valid, out_data, out_idx);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL basic_drain got=%b exp=0", out_valid);
      end
`ifdef PARSE_REJECT_CNT_EN
      checks++;
      if (rej_cnt !== 16'(rej_run)) begin
         failures++; $display("FAIL basic_rej got=%0d exp=%0d", rej_cnt, rej_run);
      end
`endif
   endtask

   task automatic test_boundary();
      logic [95:0] b, c;
      b = {72'hFFFFFF_FFFFFF_FFFFFF, 24'hD00D00};
      c = {72'hFFFFFF_FFFFFF_FFFFFF, 24'hD10D01};
      in_valid = 1; in_data = b; out_ready = 1;
      tick(); in_valid = 0; rej_run += rej_of(b);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 16'd3328 || out_idx !== 8'(2 + i)) begin
            failures++;
            $display("FAIL bound_acc%0d got=%b/%0d/%0d exp=1/3328/%0d",
                     i, out_valid, out_data, out_idx, 2 + i);
         end
         tick();
      end
      in_valid = 1; in_data = c;
      tick(); in_valid = 0; rej_run += rej_of(c);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bound_rej%0d got=%b/%b exp=0/1", i, out_valid, in_ready);
         end
         tick();
      end
`ifdef PARSE_REJECT_CNT_EN
      checks++;
      if (rej_cnt !== 16'(rej_run)) begin
         failures++; $display("FAIL bound_rejcnt got=%0d exp=%0d", rej_cnt, rej_run);
      end
`endif
   endtask

   task automatic test_all_reject();
      int n;
`ifdef PARSE_REJECT_CNT_EN
      n = 8300;
`else
      n = 64;
`endif
      in_data = '1;
      for (int i = 0; i < n; i++) begin
         in_valid = 1; out_ready = 1'($urandom_range(0, 1));
         #1;
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL allff_%0d got=%b/%b exp=1/0", i, in_ready, out_valid);
         end
         tick();
      end
      in_valid = 0;
`ifdef PARSE_REJECT_CNT_EN
      checks++;
      if (rej_cnt !== 16'hFFFF) begin
         failures++; $display("FAIL rej_sat got=%h exp=ffff", rej_cnt);
      end
`endif
   endtask

   task automatic test_random();
      int k, bi, cyc, rej_exp;
      bit fin, held;
      logic [15:0] hd;
      logic [7:0] hi;
      rst_n = 0; tick(); rst_n = 1;
      for (int p = 0; p < 2; p++) begin
         k = 0; bi = 0; cyc = 0; rej_exp = 0; fin = 0; held = 0; hd = '0; hi = '0;
         gen_stream();
         start = 1; tick(); start = 0;
         while (!fin && cyc < 4000) begin
            in_valid  = (bi < beat_q.size()) && ($urandom_range(0, 3) != 0);
            in_data   = (bi < beat_q.size()) ? beat_q[bi] : '0;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (held) begin
               checks++;
               if (out_valid !== 1'b1 || out_data !== hd || out_idx !== hi) begin
                  failures++;
                  $display("FAIL hold got=%b/%0d/%0d exp=1/%0d/%0d",
                           out_valid, out_data, out_idx, hd, hi);
               end
            end
            held = out_valid && !out_ready;
            hd = out_data; hi = out_idx;
            if (out_valid && out_ready) begin
               checks++;
               if (out_data !== 16'(exp_q[k]) || out_idx !== 8'(k) ||
                   out_last !== ((k == N-1) ? 1'b1 : 1'b0)) begin
                  failures++;
                  $display("FAIL rnd_coef p%0d got=%0d/%0d/%b exp=%0d/%0d/%b", p,
                           out_data, out_idx, out_last, exp_q[k], k, k == N-1);
               end
               fin = (k == N-1);
               k++;
            end
            if (in_valid && in_ready) begin
               rej_exp += rej_of(beat_q[bi]);
               bi++;
            end
            tick();
            cyc++;
         end
         checks++;
         if (!fin) begin
            failures++; $display("FAIL rnd_timeout got=%0d exp=%0d coefs", k, N);
         end
         checks++;
         if (bi !== last_beat + 1) begin
            failures++; $display("FAIL rnd_beats got=%0d exp=%0d", bi, last_beat + 1);
         end
         for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_data = beat_q[bi];
            #1;
            checks++;
            if (done !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
               failures++;
               $display("FAIL rnd_done%0d got=%b/%b/%b exp=1/0/0", i, done, in_ready, out_valid);
            end
            tick();
         end
         in_valid = 0;
`ifdef PARSE_REJECT_CNT_EN
         checks++;
         if (rej_cnt !== 16'(rej_exp)) begin
            failures++; $display("FAIL rnd_rej got=%0d exp=%0d", rej_cnt, rej_exp);
         end
`endif
      end
   endtask

   task automatic test_back_to_back();
      int k, cyc, bi, d1, d2;
      logic [95:0] bt;
      beat_q.delete();
      for (int b = 0; b < 12; b++) begin
         bt = '0;
         for (int g = 0; g < T; g++) begin
            d1 = $urandom_range(0, Q-1);
            d2 = $urandom_range(0, Q-1);
            bt[24*g +: 8]    = 8'(d1 & 255);
            bt[24*g+8 +: 8]  = 8'((d1 >> 8) + 16 * (d2 & 15));
            bt[24*g+16 +: 8] = 8'(d2 >> 4);
         end
         beat_q.push_back(bt);
      end
      ref_parse();
      start = 1; tick(); start = 0;
      bi = 0; k = 0; cyc = 0;
      out_ready = 1;
      while (k < 90 && cyc < 200) begin
         in_valid = (bi < beat_q.size());
         in_data  = in_valid ? beat_q[bi] : '0;
         start    = (k == 40);
         #1;
         if (k > 0 || out_valid) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'(exp_q[k]) || out_idx !== 8'(k)) begin
               failures++;
               $display("FAIL b2b_%0d got=%b/%0d/%0d exp=1/%0d/%0d",
                        k, out_valid, out_data, out_idx, exp_q[k], k);
            end
            k++;
         end
         if (in_valid && in_ready) bi++;
         tick();
         cyc++;
      end
      start = 0; in_valid = 0;
      checks++;
      if (k < 90) begin
         failures++; $display("FAIL b2b_timeout got=%0d exp=90", k);
      end
   endtask

   task automatic test_reset_mid();
      int bi, cyc, k;
      bit hit;
      rst_n = 0; tick(); rst_n = 1;
      gen_stream();
      start = 1; tick(); start = 0;
      bi = 0; cyc = 0; hit = 0;
      while (!hit && cyc < 2000) begin
         in_valid  = (bi < beat_q.size()) && ($urandom_range(0, 1) != 0);
         in_data   = (bi < beat_q.size()) ? beat_q[bi] : '0;
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         hit = out_valid && (out_idx == 8'd100);
         if (in_valid && in_ready && !hit) bi++;
         if (hit) rst_n = 0;
         tick();
         cyc++;
      end
      checks++;
      if (!hit) begin
         failures++; $display("FAIL mid_timeout got=0 exp=1");
      end
      checks++;
      if ({in_ready, out_valid, out_data, out_idx, out_last, done} !== '0) begin
         failures++;
         $display("FAIL mid_reset got=%h exp=0",
                  {in_ready, out_valid, out_data, out_idx, out_last, done});
      end
      rst_n = 1;
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL mid_idle got=%b/%b exp=0/0", in_ready, out_valid);
      end
      gen_stream();
      start = 1; tick(); start = 0;
      bi = 0; cyc = 0; k = 0;
      while (k < 20 && cyc < 500) begin
         in_valid  = (bi < beat_q.size());
         in_data   = in_valid ? beat_q[bi] : '0;
         out_ready = 1;
         #1;
         if (out_valid) begin
            checks++;
            if (out_data !== 16'(exp_q[k]) || out_idx !== 8'(k)) begin
               failures++;
               $display("FAIL mid_fresh got=%0d/%0d exp=%0d/%0d",
                        out_data, out_idx, exp_q[k], k);
            end
            k++;
         end
         if (in_valid && in_ready) bi++;
         tick();
         cyc++;
      end
      in_valid = 0;
      checks++;
      if (k < 20) begin
         failures++; $display("FAIL mid_fresh_timeout got=%0d exp=20", k);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_all_reject();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
